// File: rtl/hilo_issue_ctrl.sv
// rtl/hilo_issue_ctrl.sv - HI/LO multiply-divide issue and stall controller
// Optional issue/stall/drop counters are built when HILO_PERF_EN is defined.
module hilo_issue_ctrl #(
  parameter int MUL_CYCLES = 5,
  parameter int DIV_CYCLES = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req,
  input  logic        e_valid,
  input  logic [3:0]  e_md_op,
  input  logic        d_md_use,
  input  logic        hilo_busy,
  output logic [3:0]  hilo_op,
  output logic        start,
  output logic        stall,
  output logic [1:0]  state,
  output logic [3:0]  cnt,
  output logic        sync_err
`ifdef HILO_PERF_EN
  ,
  output logic [31:0] perf_issue,
  output logic [31:0] perf_stall,
  output logic [31:0] perf_drop
`endif
);

  if (MUL_CYCLES < 1 || MUL_CYCLES > 15) begin : g_bad_mul_cycles
    $error("hilo_issue_ctrl: MUL_CYCLES must be in 1..15");
  end
  if (DIV_CYCLES < 1 || DIV_CYCLES > 15) begin : g_bad_div_cycles
    $error("hilo_issue_ctrl: DIV_CYCLES must be in 1..15");
  end

  localparam logic [3:0] LP_MUL_N = 4'(MUL_CYCLES);
  localparam logic [3:0] LP_DIV_N = 4'(DIV_CYCLES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_t;

  state_t     r_state;
  logic [3:0] r_cnt;
  logic       r_sync_err;

  logic w_idle;
  logic w_op_read;
  logic w_op_write;
  logic w_op_long;

  assign w_idle     = (r_state == ST_IDLE);
  assign w_op_read  = e_valid && (e_md_op[3:1] == 3'b000);
  assign w_op_write = e_valid && !e_md_op[3] && (e_md_op[2:1] != 2'b00);
  assign w_op_long  = e_valid && (e_md_op[3:2] == 2'b01);

  // Reads of HI/LO are never gated by req; writes and long ops are.
  assign start = w_idle && w_op_long && !req;
  assign stall = d_md_use && (!w_idle || start);

  always_comb begin
    hilo_op = 4'hF;
    if (w_idle && (w_op_read || (w_op_write && !req))) begin
      hilo_op = e_md_op;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_cnt      <= 4'd0;
      r_sync_err <= 1'b0;
    end else begin
      if ((!w_idle) != hilo_busy) begin
        r_sync_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            // Bit 0 separates divide (5,7) from multiply (4,6).
            if (e_md_op[0]) begin
              r_state <= ST_DIV;
              r_cnt   <= LP_DIV_N;
            end else begin
              r_state <= ST_MUL;
              r_cnt   <= LP_MUL_N;
            end
          end
        end
        ST_MUL, ST_DIV: begin
          if (r_cnt <= 4'd1) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_cnt   <= 4'd0;
        end
      endcase
    end
  end

  assign state    = r_state;
  assign cnt      = r_cnt;
  assign sync_err = r_sync_err;

`ifdef HILO_PERF_EN
  logic [31:0] r_perf_issue;
  logic [31:0] r_perf_stall;
  logic [31:0] r_perf_drop;
  logic        w_drop;

  assign w_drop = w_idle && w_op_write && req;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_issue <= 32'd0;
      r_perf_stall <= 32'd0;
      r_perf_drop  <= 32'd0;
    end else begin
      r_perf_issue <= r_perf_issue + 32'(start);
      r_perf_stall <= r_perf_stall + 32'(stall);
      r_perf_drop  <= r_perf_drop + 32'(w_drop);
    end
  end

  assign perf_issue = r_perf_issue;
  assign perf_stall = r_perf_stall;
  assign perf_drop  = r_perf_drop;
`endif

endmodule

// File: tb/tb_hilo_issue_ctrl.sv
// tb/tb_hilo_issue_ctrl.sv - self-checking bench for hilo_issue_ctrl
module tb_hilo_issue_ctrl;
  localparam int MUL_N = 5;
  localparam int DIV_N = 10;

  logic       clk = 1'b0;
  logic       reset, req, e_valid, d_md_use, hilo_busy;
  logic [3:0] e_md_op;
  wire  [3:0] hilo_op;
  wire        start, stall, sync_err;
  wire  [1:0] state;
  wire  [3:0] cnt;
`ifdef HILO_PERF_EN
  wire [31:0] perf_issue, perf_stall, perf_drop;
`endif

  always #5 clk = ~clk;

  hilo_issue_ctrl #(.MUL_CYCLES(MUL_N), .DIV_CYCLES(DIV_N)) dut (
    .clk(clk), .reset(reset), .req(req), .e_valid(e_valid), .e_md_op(e_md_op),
    .d_md_use(d_md_use), .hilo_busy(hilo_busy), .hilo_op(hilo_op), .start(start),
    .stall(stall), .state(state), .cnt(cnt), .sync_err(sync_err)
`ifdef HILO_PERF_EN
    , .perf_issue(perf_issue), .perf_stall(perf_stall), .perf_drop(perf_drop)
`endif
  );

  // Model: remaining busy cycles of the unit and which kind of op occupies it.
  int          m_left;
  bit          m_div;
  bit          m_sync;
  logic [31:0] p_issue, p_stall, p_drop;
  int          checks, failures;
  logic        s_start, s_stall;
  logic [3:0]  s_op;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step(input bit r, input bit rq, input bit v, input logic [3:0] op,
                      input bit d, input bit inj);
    bit         e_idle, e_long, e_wr, e_rd, e_start, e_stall;
    logic [3:0] e_op;
    int         e_state;
    reset = r; req = rq; e_valid = v; e_md_op = op; d_md_use = d;
    hilo_busy = (m_left != 0) ^ inj;
    @(negedge clk);
    e_idle  = (m_left == 0);
    e_rd    = v && (op <= 4'd1);
    e_wr    = v && (op >= 4'd2) && (op <= 4'd7);
    e_long  = v && (op >= 4'd4) && (op <= 4'd7);
    e_start = e_idle && e_long && !rq;
    e_stall = d && (!e_idle || e_start);
    e_op    = (e_idle && (e_rd || (e_wr && !rq))) ? op : 4'hF;
    e_state = e_idle ? 0 : (m_div ? 2 : 1);
    chk("start", start, e_start);
    chk("hilo_op", hilo_op, e_op);
    chk("stall", stall, e_stall);
    chk("state", state, e_state);
    chk("cnt", cnt, m_left);
    chk("sync_err", sync_err, m_sync);
`ifdef HILO_PERF_EN
    chk("perf_issue", perf_issue, p_issue);
    chk("perf_stall", perf_stall, p_stall);
    chk("perf_drop", perf_drop, p_drop);
`endif
    s_start = start; s_stall = stall; s_op = hilo_op;
    if (r) begin
      m_left = 0; m_div = 0; m_sync = 0;
      p_issue = 0; p_stall = 0; p_drop = 0;
    end else begin
      if ((m_left != 0) != hilo_busy) m_sync = 1;
      p_issue += 32'(e_start);
      p_stall += 32'(e_stall);
      p_drop  += 32'(e_idle && e_wr && rq);
      if (m_left > 0) m_left--;
      else if (e_start) begin
        m_div  = op[0];
        m_left = op[0] ? DIV_N : MUL_N;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_steps(input int n, input bit d);
    for (int i = 0; i < n; i++) step(0, 0, 0, 4'd0, d, 0);
  endtask

  initial begin
    int nst;
    checks = 0; failures = 0;
    m_left = 0; m_div = 0; m_sync = 0;
    p_issue = 0; p_stall = 0; p_drop = 0;
    reset = 1; req = 0; e_valid = 0; e_md_op = 0; d_md_use = 0; hilo_busy = 0;

    step(1, 0, 0, 4'd0, 0, 0);
    step(1, 0, 0, 4'd0, 0, 0);
    chk("rst_state", state, 0);
    chk("rst_cnt", cnt, 0);
    chk("rst_sync", sync_err, 0);
    chk("rst_hilo_op", s_op, 4'hF);
    chk("rst_start", s_start, 0);

    // mult countdown 5..1 then IDLE
    step(0, 0, 1, 4'd6, 0, 0);
    chk("mul_start", s_start, 1);
    chk("mul_op", s_op, 6);
    chk("mul_state", state, 1);
    chk("mul_cnt5", cnt, 5);
    for (int k = 4; k >= 1; k--) begin
      step(0, 0, 0, 4'd0, 0, 0);
      chk("mul_cnt", cnt, k);
    end
    step(0, 0, 0, 4'd0, 0, 0);
    chk("mul_done_state", state, 0);
    chk("mul_sync", sync_err, 0);

    // divu with mflo waiting in D: 11 stall cycles
    nst = 0;
    step(0, 0, 1, 4'd5, 1, 0);
    nst += int'(s_stall);
    for (int i = 0; i < 12; i++) begin
      step(0, 0, 0, 4'd0, 1, 0);
      nst += int'(s_stall);
    end
    chk("divu_stall_cycles", nst, 11);
    step(0, 0, 1, 4'd1, 0, 0);
    chk("mflo_op", s_op, 1);

    // req suppresses multu and mtlo
    step(0, 1, 1, 4'd4, 0, 0);
    chk("req_multu_start", s_start, 0);
    chk("req_multu_op", s_op, 4'hF);
    chk("req_multu_state", state, 0);
    step(0, 1, 1, 4'd3, 0, 0);
    chk("req_mtlo_op", s_op, 4'hF);
`ifdef HILO_PERF_EN
    chk("perf_drop_two", perf_drop, 2);
`endif

    // req pulse at cnt=3 during div does not disturb countdown
    step(0, 0, 1, 4'd7, 0, 0);
    idle_steps(7, 0);
    chk("div_cnt3", cnt, 3);
    step(0, 1, 1, 4'd6, 1, 0);
    chk("div_req_cnt2", cnt, 2);
    step(0, 0, 0, 4'd0, 1, 0);
    chk("div_req_cnt1", cnt, 1);
    step(0, 0, 0, 4'd0, 1, 0);
    chk("div_req_idle", state, 0);
    step(0, 0, 0, 4'd0, 1, 0);
    chk("div_req_nostall", s_stall, 0);

    // reset at cnt=6 during div, then a clean mult
    step(0, 0, 1, 4'd7, 0, 0);
    idle_steps(4, 0);
    chk("div_cnt6", cnt, 6);
    step(1, 0, 0, 4'd0, 1, 0);
    chk("midrst_state", state, 0);
    chk("midrst_cnt", cnt, 0);
    chk("midrst_sync", sync_err, 0);
    step(0, 0, 0, 4'd0, 1, 0);
    chk("midrst_stall", s_stall, 0);
    step(0, 0, 1, 4'd6, 0, 0);
    chk("post_rst_start", s_start, 1);
    chk("post_rst_cnt", cnt, 5);
    idle_steps(5, 0);

    // busy forced low during MUL: sticky sync_err
    step(0, 0, 1, 4'd6, 0, 0);
    step(0, 0, 0, 4'd0, 0, 1);
    chk("sync_set", sync_err, 1);
    idle_steps(5, 0);
    chk("sync_done_state", state, 0);
    chk("sync_sticky", sync_err, 1);
    step(1, 0, 0, 4'd0, 0, 0);
    chk("sync_cleared", sync_err, 0);

    // randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      bit         r, rq, v, d, inj;
      logic [3:0] op;
      r   = ($urandom_range(0, 199) == 0);
      rq  = ($urandom_range(0, 5) == 0);
      v   = 1'($urandom_range(0, 1));
      op  = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(8, 15)) : 4'($urandom_range(0, 7));
      d   = 1'($urandom_range(0, 1));
      inj = ($urandom_range(0, 299) == 0);
      step(r, rq, v, op, d, inj);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/hilo_issue_ctrl.md
Name: hilo_issue_ctrl

Overview:
Issue and stall controller for the HI/LO multiply-divide unit in the pipelined MIPS core. Sits in the E stage between decode-supplied MD op codes and the HI/LO unit, and drives the unit's op code and start strobe. Mirrors the unit's busy window with its own countdown, so it can:
- stall D-stage HI/LO-family instructions,
- gate issue and HI/LO writes on exception/interrupt requests (req),
- flag desynchronisation against the unit's busy output.

Parameters:
- MUL_CYCLES, 5, busy cycles after a mult/multu issue edge; legal range 1..15.
- DIV_CYCLES, 10, busy cycles after a div/divu issue edge; legal range 1..15.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high reset.
- req  in  1  exception/interrupt flush request this cycle.
- e_valid  in  1  E-stage instruction is valid.
- e_md_op  in  4  E-stage op: 0 mfhi, 1 mflo, 2 mthi, 3 mtlo, 4 multu, 5 divu, 6 mult, 7 div; other codes = not MD.
- d_md_use  in  1  D-stage instruction is any op 0..7.
- hilo_busy  in  1  busy output of the HI/LO unit.
- hilo_op  out  4  op code driven to the HI/LO unit; 4'hF = no-op.
- start  out  1  combinational issue strobe for ops 4..7.
- stall  out  1  freeze F/D, bubble into E.
- state  out  2  0 IDLE, 1 MUL, 2 DIV.
- cnt  out  4  remaining busy cycles.
- sync_err  out  1  sticky mismatch flag.

Behaviour:
- Reset values: state=IDLE, cnt=0, sync_err=0, perf counters=0. Outputs then follow the combinational rules below: start=0 and hilo_op=4'hF unless E presents a valid op.
- hilo_op, IDLE:
  - e_valid and op 0/1 -> pass through (reads are never gated).
  - op 2..7 -> pass only when !req, else 4'hF.
  - not valid, or other code -> 4'hF.
- hilo_op, MUL/DIV: forced to 4'hF.
- Issue: start = (state==IDLE) && e_valid && e_md_op in 4..7 && !req.
  - On the start edge: state <= MUL (ops 4,6) or DIV (ops 5,7).
  - cnt <= MUL_CYCLES or DIV_CYCLES respectively.
- Countdown in MUL/DIV: cnt decrements every cycle. When cnt==1: state <= IDLE, cnt <= 0.
  - Busy therefore lasts exactly N cycles after the issue edge, identical to the unit.
  - IDLE is the cycle the unit's HI/LO results are visible.
- stall = d_md_use && (state!=IDLE || start). The issue cycle stalls the next MD instruction.
- req during MUL/DIV: no cancellation; countdown continues and the result is committed. req only blocks new issue and mthi/mtlo in the same cycle.
- Simultaneous req and start-eligible op: no issue, state stays IDLE, hilo_op=4'hF.
- E-stage MD op arriving while not IDLE: not issued. This is a protocol violation prevented by stall; the controller ignores it without corrupting state.
- sync_err: set when (state!=IDLE) != hilo_busy on any cycle with reset low. Cleared only by reset.
- Reset mid-operation: state/cnt return to IDLE/0 the same edge the unit resets; no further stall.
- Parameter values of 0 or >15 are illegal. Simulation must stop with $error at time 0.

Optional Feature:
Macro HILO_PERF_EN.
- Defined: adds outputs perf_issue[31:0], perf_stall[31:0] and perf_drop[31:0].
  - perf_issue increments on each start.
  - perf_stall increments on each stall cycle.
  - perf_drop increments when req suppresses an op 2..7 in IDLE.
  - All three wrap modulo 2^32 and reset to 0.
- Undefined: those ports and counters do not exist; all other behaviour is identical.

Test Plan:
- mult (e_md_op=6) in IDLE, req=0 -> start=1, hilo_op=6 that cycle. Then state=MUL with cnt 5,4,3,2,1 and hilo_busy=1 for 5 cycles; IDLE on the 6th; sync_err=0.
- divu (5) followed by D-stage mflo (d_md_use=1) -> stall high for the issue cycle plus 10 busy cycles (11 total). mflo reaches E with hilo_op=1 once state=IDLE.
- multu with req=1 -> start=0, hilo_op=4'hF, state stays IDLE. mtlo with req=1 -> hilo_op=4'hF; perf_drop=2 with HILO_PERF_EN.
- req pulsed at cnt=3 during div -> countdown continues to IDLE on schedule, no restart, no extra stall cycles.
- reset asserted at cnt=6 during div -> next edge: state=IDLE, cnt=0, stall=0, sync_err=0. A following mult issues normally.
- hilo_busy forced 0 while state=MUL -> sync_err=1 next edge and stays 1 after the op completes until reset.
